// File: rtl/mem_access_if.sv
// mem_access_if: req/ack data-bus bundle between the memory stage and the data memory.
interface mem_access_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_ack_i, mem_rdata_i
  );
  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: memory stage issuing loads/stores over a req/ack bus and forwarding write-back fields.
// Optional MEM_MISALIGN_EXC_EN: misaligned half/word accesses are refused and reported.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] exmem_reg_wdata_i,
  input  logic [4:0]  exmem_reg_waddr_i,
  input  logic        exmem_reg_we_i,
  input  logic [31:0] exmem_csr_wdata_i,
  input  logic [11:0] exmem_csr_waddr_i,
  input  logic        exmem_csr_we_i,
  input  logic        exmem_mem_re_i,
  input  logic        exmem_mem_we_i,
  input  logic [2:0]  exmem_mem_op_i,
  input  logic [31:0] exmem_mem_addr_i,
  input  logic [31:0] exmem_mem_wdata_i,
  mem_access_if.master bus,
  output logic [31:0] mem_reg_wdata_o,
  output logic [4:0]  mem_reg_waddr_o,
  output logic        mem_reg_we_o,
  output logic [31:0] mem_csr_wdata_o,
  output logic [11:0] mem_csr_waddr_o,
  output logic        mem_csr_we_o,
  output logic        mem_stall_req_o,
  output logic        mem_err_o,
`ifdef MEM_MISALIGN_EXC_EN
  output logic        mem_misalign_o,
  output logic [31:0] mem_misalign_addr_o,
`endif
  input  logic        fc_flush_mem_i
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  state_e      state_q;
  logic        req_q, we_q, err_q, to_q, ld_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt_q;
  logic        acc, mis, issue, pass, done, ok;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ext;
  logic [7:0]  lb;
  logic [15:0] lh;
  assign acc = exmem_mem_re_i | exmem_mem_we_i;
`ifdef MEM_MISALIGN_EXC_EN
  assign mis = acc & ((exmem_mem_op_i[1:0] == 2'b01 & exmem_mem_addr_i[0]) |
                      (exmem_mem_op_i[1:0] == 2'b10 & |exmem_mem_addr_i[1:0]));
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    issue   = state_q == IDLE & acc & ~fc_flush_mem_i & ~mis;
    pass    = state_q == IDLE & ~acc;
    done    = state_q == DONE;
    ok      = ~fc_flush_mem_i & (pass | (done & ~to_q));
    be_d    = exmem_mem_op_i[1] ? 4'hf :
              exmem_mem_op_i[0] ? 4'b0011 << {exmem_mem_addr_i[1], 1'b0} :
                                  4'b0001 << exmem_mem_addr_i[1:0];
    wdata_d = exmem_mem_op_i[1] ? exmem_mem_wdata_i :
              exmem_mem_op_i[0] ? {2{exmem_mem_wdata_i[15:0]}} : {4{exmem_mem_wdata_i[7:0]}};
    lb      = rdata_q[{off_q, 3'b000} +: 8];
    lh      = rdata_q[{off_q[1], 4'b0000} +: 16];
    ext     = op_q[1] ? rdata_q :
              op_q[0] ? {{16{~op_q[2] & lh[15]}}, lh} : {{24{~op_q[2] & lb[7]}}, lb};
  end
  assign mem_stall_req_o = issue | state_q == REQ;
  assign mem_reg_we_o    = ok & exmem_reg_we_i & (pass | ld_q);
  assign mem_csr_we_o    = ok & exmem_csr_we_i;
  assign mem_reg_wdata_o = done & ld_q ? ext : exmem_reg_wdata_i;
  assign mem_reg_waddr_o = exmem_reg_waddr_i;
  assign mem_csr_wdata_o = exmem_csr_wdata_i;
  assign mem_csr_waddr_o = exmem_csr_waddr_i;
  assign mem_err_o       = err_q;
  assign bus.mem_req_o   = req_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_be_o    = be_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      ld_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      op_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (issue) begin
          state_q <= REQ;
          req_q   <= 1'b1;
          we_q    <= exmem_mem_we_i;
          ld_q    <= exmem_mem_re_i & ~exmem_mem_we_i;
          addr_q  <= {exmem_mem_addr_i[31:2], 2'b00};
          wdata_q <= wdata_d;
          be_q    <= be_d;
          op_q    <= exmem_mem_op_i;
          off_q   <= exmem_mem_addr_i[1:0];
          cnt_q   <= '0;
          to_q    <= 1'b0;
        end
        REQ: begin
          // flush wins over a same-cycle ack or timeout: the access simply vanishes
          if (fc_flush_mem_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
          end else if (bus.mem_ack_i) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= bus.mem_rdata_i;
          end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b1;
            to_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef MEM_MISALIGN_EXC_EN
  logic        mis_q;
  logic [31:0] mis_addr_q;
  assign mem_misalign_o      = mis_q;
  assign mem_misalign_addr_o = mis_addr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      mis_q <= state_q == IDLE & mis & ~fc_flush_mem_i;
      if (state_q == IDLE & mis & ~fc_flush_mem_i) mis_addr_q <= exmem_mem_addr_i;
    end
  end
`endif
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access pipeline stage, directly upstream of the EX/MEM→MEM/WB path that feeds the write-back stage.
- Issues loads and stores to the data bus through a req/ack handshake and stalls the pipeline via flow control until the access completes.
- Aligns and sign/zero-extends load data, then forwards register and CSR write-back fields to the MEM/WB register.
- Non-memory instructions pass through with zero added latency.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in REQ without mem_ack_i before the access is aborted; legal range 1-255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- exmem_reg_wdata_i  in  32  ALU/CSR result for rd.
- exmem_reg_waddr_i  in  5  rd.
- exmem_reg_we_i  in  1  rd write enable.
- exmem_csr_wdata_i  in  32  CSR write data.
- exmem_csr_waddr_i  in  12  CSR address.
- exmem_csr_we_i  in  1  CSR write enable.
- exmem_mem_re_i  in  1  load.
- exmem_mem_we_i  in  1  store.
- exmem_mem_op_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- exmem_mem_addr_i  in  32  byte address.
- exmem_mem_wdata_i  in  32  store data, unshifted.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  bus write.
- mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata_o  out  32  lane-shifted store data.
- mem_be_o  out  4  byte enables.
- mem_ack_i  in  1  bus completion; rdata valid in the same cycle.
- mem_rdata_i  in  32  bus read word.
- mem_reg_wdata_o  out  32  to MEM/WB register.
- mem_reg_waddr_o  out  5  to MEM/WB register.
- mem_reg_we_o  out  1  to MEM/WB register.
- mem_csr_wdata_o  out  32  to MEM/WB register.
- mem_csr_waddr_o  out  12  to MEM/WB register.
- mem_csr_we_o  out  1  to MEM/WB register.
- mem_stall_req_o  out  1  to flow control; freezes IF..EX/MEM.
- mem_err_o  out  1  one-cycle pulse on bus timeout.
- fc_flush_mem_i  in  1  from flow control; kill current access.

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset: state=IDLE; all registered outputs 0 (mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_err_o); timeout counter 0.
- IDLE, no access (re=we=0): combinational pass-through of reg/csr fields; mem_stall_req_o=0.
- IDLE, access and no flush: latch addr, be, shifted wdata and op; go to REQ. mem_stall_req_o=1 combinationally; mem_reg_we_o=0 and mem_csr_we_o=0.
- REQ: mem_req_o=1, stall=1, counter increments each cycle.
  - mem_ack_i: capture mem_rdata_i into the load buffer; go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: drop req; pulse mem_err_o; go to DONE with write-back suppressed.
- DONE: stall=0; outputs valid for one cycle; reg_we = exmem_reg_we_i (unless timed out); next state IDLE. Minimum load/store: 1 IDLE + 1 REQ + 1 DONE.
- Lane encoding:
  - B/BU: be = 4'b0001 << addr[1:0].
  - H/HU: be = 4'b0011 << (addr[1]*2).
  - W: be = 4'b1111.
  - Store data replicated: byte {4{b}}, half {2{h}}.
- Load extraction: select byte/half by addr[1:0]; B/H sign-extend, BU/HU zero-extend. Load result replaces reg_wdata. Stores never write rd.
- Flush:
  - In IDLE or DONE: suppress reg/csr we this cycle.
  - In REQ: deassert req next cycle; an ack arriving in the same cycle is discarded; go to IDLE, stall=0, no write-back.
- rst in any state: IDLE next cycle; the in-flight access is abandoned and a late ack is ignored.
- Back-to-back accesses: DONE→IDLE→REQ. The next access starts in the cycle after DONE. No pipelined outstanding requests.

Optional Feature:
- Macro MEM_MISALIGN_EXC_EN.
- Defined:
  - Misaligned half (addr[0]=1) or word (addr[1:0]!=0) access is not issued.
  - Stays in IDLE with stall=0; rd/csr writes suppressed.
  - Output mem_misalign_o (1-bit, added port) pulses for one cycle, along with mem_misalign_addr_o (32-bit) holding the faulting address.
- Undefined: ports absent; addr[1:0] ignored for lane selection beyond the encoding above (H with addr[0]=1 uses addr[1] only).

Test Plan:
- LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF → stall high 4 cycles; DONE: reg_wdata=0xDEADBEEF, reg_we=1.
- LB addr 0x203, rdata 0x80FF_0000 → be 4'b1000; reg_wdata=0xFFFF_FF80. Same with LBU → 0x0000_0080.
- SH addr 0x302, wdata 0x1234ABCD → mem_wdata_o=0xABCDABCD, be=4'b1100, mem_we_o=1; mem_reg_we_o=0.
- LW with no ack, TIMEOUT_CYCLES=4 → req high exactly 4 cycles; mem_err_o pulse; no rd write; stall released.
- fc_flush_mem_i in 2nd REQ cycle with simultaneous ack → no write-back; IDLE next; stall=0.
- ALU op (re=we=0, rd=5, wdata=7) → same-cycle pass-through, stall=0. MEM_MISALIGN_EXC_EN: LW 0x102 → mem_misalign_o=1, addr=0x102, req never asserted.
